// File: rtl/cq_viola_sysid_checker.sv
// Reads the system-ID and timestamp words over Avalon-MM and reports whether they
// match the build values, with bounded waitrequest timeout and mismatch retries.
module cq_viola_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID = 32'd538182181,
  parameter logic [31:0] EXPECTED_TS = 32'd1399996659,
  parameter int unsigned START_DELAY = 16,
  parameter int unsigned TIMEOUT     = 255,
  parameter int unsigned MAX_RETRY   = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout
);

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned RETRY_W = 4;

  typedef enum logic [2:0] {
    S_WAIT,
    S_RD_ID,
    S_RD_TS,
    S_CHECK,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0]   delay_q, delay_d;
  logic [CNT_W-1:0]   to_q, to_d;
  logic [RETRY_W-1:0] retry_q, retry_d;

  logic              avm_address_d, avm_read_d, busy_d, done_d;
  logic              id_ok_d, ts_ok_d, timeout_d;
  logic [DATA_W-1:0] id_value_d, ts_value_d;

  logic xfer_c, stall_c, to_expire_c, id_match_c, ts_match_c, retry_left_c;

  assign xfer_c       = avm_read & ~avm_waitrequest;
  assign stall_c      = avm_read & avm_waitrequest;
  assign to_expire_c  = stall_c && (to_q == CNT_W'(TIMEOUT - 1));
  assign id_match_c   = (id_value == EXPECTED_ID);
  assign ts_match_c   = (ts_value == EXPECTED_TS);
  assign retry_left_c = (retry_q < RETRY_W'(MAX_RETRY));

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= S_WAIT;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT:  if (delay_q <= CNT_W'(1)) state_d = S_RD_ID;
      S_RD_ID: begin
        if (xfer_c)           state_d = S_RD_TS;
        else if (to_expire_c) state_d = S_DONE;
      end
      S_RD_TS: begin
        if (xfer_c)           state_d = S_CHECK;
        else if (to_expire_c) state_d = S_DONE;
      end
      S_CHECK: begin
        if (id_match_c && ts_match_c) state_d = S_DONE;
        else if (retry_left_c)        state_d = S_RD_ID;
        else                          state_d = S_DONE;
      end
      S_DONE:  if (start) state_d = S_RD_ID;
      default: state_d = S_WAIT;
    endcase
  end

  // Output and datapath next values; bus outputs follow the upcoming state so they are registered
  always_comb begin
    delay_d       = delay_q;
    to_d          = to_q;
    retry_d       = retry_q;
    id_value_d    = id_value;
    ts_value_d    = ts_value;
    id_ok_d       = id_ok;
    ts_ok_d       = ts_ok;
    timeout_d     = timeout;
    avm_read_d    = (state_d == S_RD_ID) || (state_d == S_RD_TS);
    avm_address_d = (state_d == S_RD_TS);
    busy_d        = (state_d != S_DONE);
    done_d        = (state_d == S_DONE);

    if ((state_d == S_RD_ID || state_d == S_RD_TS) && state_d != state_q)
      to_d = '0;
    else if (stall_c && to_q != '1)
      to_d = to_q + CNT_W'(1);

    case (state_q)
      S_WAIT: if (delay_q > CNT_W'(1)) delay_d = delay_q - CNT_W'(1);
      S_RD_ID, S_RD_TS: begin
        if (xfer_c) begin
          if (state_q == S_RD_ID) id_value_d = avm_readdata;
          else                    ts_value_d = avm_readdata;
        end else if (to_expire_c) begin
          timeout_d = 1'b1;
          id_ok_d   = 1'b0;
          ts_ok_d   = 1'b0;
        end
      end
      S_CHECK: begin
        if (state_d == S_DONE) begin
          id_ok_d = id_match_c;
          ts_ok_d = ts_match_c;
        end else begin
          retry_d = retry_q + RETRY_W'(1);
        end
      end
      S_DONE: begin
        if (start) begin
          id_ok_d   = 1'b0;
          ts_ok_d   = 1'b0;
          timeout_d = 1'b0;
          retry_d   = '0;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      delay_q     <= CNT_W'(START_DELAY);
      to_q        <= '0;
      retry_q     <= '0;
      avm_address <= 1'b0;
      avm_read    <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      delay_q     <= delay_d;
      to_q        <= to_d;
      retry_q     <= retry_d;
      avm_address <= avm_address_d;
      avm_read    <= avm_read_d;
      id_value    <= id_value_d;
      ts_value    <= ts_value_d;
      busy        <= busy_d;
      done        <= done_d;
      id_ok       <= id_ok_d;
      ts_ok       <= ts_ok_d;
      timeout     <= timeout_d;
    end
  end

endmodule
